// File: rtl/fine_track_gear_ctrl.sv
// Gear-shifting sequencer for the fine frequency tracking loop.
// Halves step / widens window on reversals, locks once step-1 decisions dither.
module fine_track_gear_ctrl #(
   parameter int INIT_STEP   = 8,
   parameter int INIT_WIN    = 4,
   parameter int MAX_WIN     = 12,
   parameter int REV_CNT     = 2,
   parameter int LOCK_CNT    = 4,
   parameter int UNLOCK_CNT  = 3,
   parameter int SYNC_STAGES = 2
) (
   input  logic       clk_out,
   input  logic       rst,
   input  logic       track_en,
   input  logic       commit_tog,
   input  logic [1:0] dec,
   output logic [3:0] fine_con_step_size,
   output logic [4:0] fine_control_avg_window_select,
   output logic       loop_rst,
   output logic       locked,
   output logic [1:0] state
);

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      ACQ    = 2'd1,
      FINE   = 2'd2,
      LOCKED = 2'd3
   } state_t;

   typedef enum logic [1:0] {
      DIR_NONE = 2'd0,
      DIR_UP   = 2'd1,
      DIR_DN   = 2'd2
   } dir_t;

   localparam logic [3:0] STEP0    = 4'(INIT_STEP);
   localparam logic [4:0] WIN0     = 5'(INIT_WIN);
   localparam logic [4:0] WIN_MAX  = 5'(MAX_WIN);
   localparam logic [2:0] REV_N    = 3'(REV_CNT);
   localparam logic [3:0] LOCK_N   = 4'(LOCK_CNT);
   localparam logic [3:0] UNLOCK_N = 4'(UNLOCK_CNT);

   logic [SYNC_STAGES-1:0] sync;
   logic                   sync_prev;
   logic                   commit_evt;

   state_t     state_q, state_d;
   dir_t       last_q, last_d, dir;
   logic [3:0] step_q, step_d, step_half;
   logic [4:0] win_q, win_d, win_up;
   logic [2:0] rev_q, rev_d;
   logic [3:0] run_q, run_d, run_inc;
   logic       locked_q, locked_d;
   logic       lr_d, hold_q, hold_d;
   logic       accept;

   always_ff @(posedge clk_out or posedge rst) begin
      if (rst) begin
         sync       <= '0;
         sync_prev  <= 1'b0;
         commit_evt <= 1'b0;
      end else begin
         sync       <= {sync[SYNC_STAGES-2:0], commit_tog};
         sync_prev  <= sync[SYNC_STAGES-1];
         commit_evt <= sync[SYNC_STAGES-1] ^ sync_prev;
      end
   end

   always_comb begin
      dir = DIR_NONE;
      case (dec)
         2'b01:   dir = DIR_UP;
         2'b10:   dir = DIR_DN;
         default: dir = DIR_NONE;
      endcase
   end

   assign step_half = (step_q > 4'd1) ? {1'b0, step_q[3:1]} : 4'd1;
   assign win_up    = (win_q >= WIN_MAX) ? WIN_MAX : win_q + 5'd1;
   assign run_inc   = run_q + 4'd1;
   // Commits seen while the loop is being reset carry stale accumulator data.
   assign accept    = commit_evt & ~loop_rst;

   always_comb begin
      state_d  = state_q;
      step_d   = step_q;
      win_d    = win_q;
      locked_d = locked_q;
      last_d   = last_q;
      rev_d    = rev_q;
      run_d    = run_q;
      lr_d     = hold_q;
      hold_d   = 1'b0;
      if (!track_en) begin
         state_d  = IDLE;
         step_d   = STEP0;
         win_d    = WIN0;
         locked_d = 1'b0;
         last_d   = DIR_NONE;
         rev_d    = '0;
         run_d    = '0;
         lr_d     = 1'b0;
      end else begin
         unique case (state_q)
            IDLE: begin
               state_d = ACQ;
               lr_d    = 1'b1;
               hold_d  = 1'b1;
            end
            ACQ: if (accept && dir != DIR_NONE) begin
               last_d = dir;
               if (last_q != DIR_NONE && dir != last_q) begin
                  rev_d = rev_q + 3'd1;
                  if (rev_d == REV_N) begin
                     step_d = step_half;
                     win_d  = win_up;
                     rev_d  = '0;
                     last_d = DIR_NONE;
                     lr_d   = 1'b1;
                     hold_d = 1'b1;
                     if (step_half == 4'd1) state_d = FINE;
                  end
               end
            end
            FINE: if (accept) begin
               if (dir != DIR_NONE) last_d = dir;
               if (dir != DIR_NONE && dir == last_q) begin
                  run_d = '0;
               end else if (run_inc == LOCK_N) begin
                  state_d  = LOCKED;
                  locked_d = 1'b1;
                  run_d    = '0;
               end else begin
                  run_d = run_inc;
               end
            end
            LOCKED: if (accept) begin
               if (dir == DIR_NONE) begin
                  run_d = '0;
               end else begin
                  // run_cnt is the length of the current same-direction run
                  last_d = dir;
                  run_d  = (dir == last_q) ? run_inc : 4'd1;
                  if (run_d == UNLOCK_N) begin
                     state_d  = ACQ;
                     step_d   = STEP0;
                     win_d    = WIN0;
                     locked_d = 1'b0;
                     last_d   = DIR_NONE;
                     rev_d    = '0;
                     run_d    = '0;
                     lr_d     = 1'b1;
                     hold_d   = 1'b1;
                  end
               end
            end
         endcase
      end
   end

   always_ff @(posedge clk_out or posedge rst) begin
      if (rst) begin
         state_q  <= IDLE;
         step_q   <= STEP0;
         win_q    <= WIN0;
         locked_q <= 1'b0;
         last_q   <= DIR_NONE;
         rev_q    <= '0;
         run_q    <= '0;
         loop_rst <= 1'b0;
         hold_q   <= 1'b0;
      end else begin
         state_q  <= state_d;
         step_q   <= step_d;
         win_q    <= win_d;
         locked_q <= locked_d;
         last_q   <= last_d;
         rev_q    <= rev_d;
         run_q    <= run_d;
         loop_rst <= lr_d;
         hold_q   <= hold_d;
      end
   end

   assign fine_con_step_size             = step_q;
   assign fine_control_avg_window_select = win_q;
   assign locked                         = locked_q;
   assign state                          = state_q;

endmodule
